// File: rtl/ram_ctrl.sv
// ram_ctrl: byte-addressed main memory with a valid/ready request port,
// programmable wait states and unaligned accesses split into two row beats.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    request present         req_ready  block can accept
//   req_we       1 = write, 0 = read     req_be     per-lane byte enables
//   req_addr     byte address of lane 0  req_wdata  write data, lane i at [8i+:8]
//   rsp_valid    one-cycle response      rsp_rdata  read data by lane
//   rsp_err      an enabled byte was at or above DEPTH
module ram_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int DATA_BYTES  = 2,
    parameter int DEPTH       = 786432,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_BYTES-1:0]   req_be,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [8*DATA_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    rsp_err
);

    localparam int OFF_W  = $clog2(DATA_BYTES);
    localparam int MEM_AW = $clog2(DEPTH);
    localparam int DW     = 8 * DATA_BYTES;
    localparam logic [4:0] W0_LD = 5'(WAIT_STATES);
    // beat 1 costs its own beat cycle plus the wait states
    localparam logic [4:0] W1_LD = 5'(WAIT_STATES + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT0,
        WAIT1,
        BEAT1
    } state_t;

    state_t state, state_nx;
    logic [4:0] cnt, cnt_nx;

    logic                  lat_we;
    logic [DATA_BYTES-1:0] lat_be;
    logic [ADDR_W-1:0]     lat_addr;
    logic [DW-1:0]         lat_wdata;

    logic [DW-1:0] acc_rdata;
    logic          acc_err;

    logic [7:0] mem [DEPTH];

    logic                  accept;
    logic                  cur_we;
    logic [DATA_BYTES-1:0] cur_be;
    logic [ADDR_W-1:0]     cur_addr;
    logic [DW-1:0]         cur_wdata;
    logic                  beat_sel;
    logic                  two;
    logic                  exec;
    logic                  last;
    logic [DATA_BYTES-1:0] carry;
    logic [DATA_BYTES-1:0] in_rng;
    logic [DATA_BYTES-1:0] lane_on;
    logic [ADDR_W-1:0]     lane_addr [DATA_BYTES];
    logic [DW-1:0]         bdata;
    logic                  berr;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign beat_sel  = (state == WAIT1) || (state == BEAT1);

    // In IDLE the beat runs straight from the port; later beats use the latch.
    always_comb begin
        cur_we    = lat_we;
        cur_be    = lat_be;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        if (state == IDLE) begin
            cur_we    = req_we;
            cur_be    = req_be;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
    end

    // A lane lands in the next row when its offset within the row carries out.
    always_comb begin
        carry   = '0;
        in_rng  = '0;
        lane_on = '0;
        bdata   = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            lane_addr[i] = cur_addr + ADDR_W'(i);
            carry[i]  = (32'(cur_addr[OFF_W-1:0]) + 32'(i)) >= 32'(DATA_BYTES);
            in_rng[i] = 64'(lane_addr[i]) < 64'(DEPTH);
            lane_on[i] = cur_be[i] && (carry[i] == beat_sel);
            if (lane_on[i] && in_rng[i] && !cur_we)
                bdata[8*i +: 8] = mem[lane_addr[i][MEM_AW-1:0]];
        end
        two  = |(cur_be & carry);
        berr = |(lane_on & ~in_rng);
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        exec     = 1'b0;
        unique case (state)
            IDLE: begin
                exec = accept && (WAIT_STATES == 0);
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_nx = two ? BEAT1 : IDLE;
                    end else begin
                        state_nx = WAIT0;
                        cnt_nx   = W0_LD;
                    end
                end
            end
            WAIT0: begin
                exec   = (cnt == 5'd1);
                cnt_nx = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    if (two) begin
                        state_nx = WAIT1;
                        cnt_nx   = W1_LD;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            WAIT1: begin
                exec   = (cnt == 5'd1);
                cnt_nx = cnt - 5'd1;
                if (cnt == 5'd1)
                    state_nx = IDLE;
            end
            BEAT1: begin
                exec     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        last = exec && (beat_sel || !two);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            acc_rdata <= '0;
            acc_err   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rsp_valid <= last;
            if (accept) begin
                lat_we    <= req_we;
                lat_be    <= req_be;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (exec) begin
                if (last) begin
                    rsp_rdata <= (beat_sel ? acc_rdata : '0) | bdata;
                    rsp_err   <= (beat_sel && acc_err) || berr;
                end else begin
                    acc_rdata <= bdata;
                    acc_err   <= berr;
                end
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (exec && cur_we && rst_n) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (lane_on[i] && in_rng[i])
                    mem[lane_addr[i][MEM_AW-1:0]] <= cur_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: two ram_ctrl instances (no wait states / three wait states)
// driven with directed and random traffic against a byte-array model.
module tb_ram_ctrl;

    localparam int AW   = 12;
    localparam int DB   = 4;
    localparam int NI   = 2;
    localparam int DEP0 = 4000;
    localparam int DEP1 = 3000;
    localparam int WS0  = 0;
    localparam int WS1  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n     [NI];
    logic          req_valid [NI];
    logic          req_ready [NI];
    logic          req_we    [NI];
    logic [DB-1:0] req_be    [NI];
    logic [AW-1:0] req_addr  [NI];
    logic [31:0]   req_wdata [NI];
    logic          rsp_valid [NI];
    logic [31:0]   rsp_rdata [NI];
    logic          rsp_err   [NI];

    ram_ctrl #(.ADDR_W(AW), .DATA_BYTES(DB), .DEPTH(DEP0), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_be(req_be[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    ram_ctrl #(.ADDR_W(AW), .DATA_BYTES(DB), .DEPTH(DEP1), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_be(req_be[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    int vecs = 0;
    int errs = 0;
    logic [7:0] mdl [int];
    logic [31:0] rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dep(input int k);
        return (k == 0) ? DEP0 : DEP1;
    endfunction

    function automatic int ws(input int k);
        return (k == 0) ? WS0 : WS1;
    endfunction

    // Whole-request semantics: every enabled byte is read or written at once.
    function automatic void model(input int k, input bit we, input logic [3:0] be,
                                  input logic [11:0] addr, input logic [31:0] wd,
                                  output logic [31:0] erd, output bit eerr, output int nb);
        int a;
        int key;
        erd  = '0;
        eerr = 1'b0;
        nb   = 1;
        for (int i = 0; i < DB; i++) begin
            if (be[i]) begin
                a   = (int'(addr) + i) % 4096;
                key = k * 4096 + a;
                if (a / DB != int'(addr) / DB)
                    nb = 2;
                if (a >= dep(k))
                    eerr = 1'b1;
                else if (we)
                    mdl[key] = wd[8*i +: 8];
                else
                    erd[8*i +: 8] = mdl.exists(key) ? mdl[key] : 8'hxx;
            end
        end
    endfunction

    task automatic scramble(input int k);
        req_valid[k] = 1'b0;
        req_we[k]    = 1'($urandom);
        req_be[k]    = 4'($urandom);
        req_addr[k]  = 12'($urandom);
        req_wdata[k] = $urandom;
    endtask

    task automatic do_req(input int k, input bit we, input logic [3:0] be,
                          input logic [11:0] addr, input logic [31:0] wd,
                          output logic [31:0] got_rd);
        logic [31:0] erd;
        bit eerr;
        int nb;
        int lat;
        int exp_lat;
        bit got;
        @(negedge clk);
        chk("rsp_pulse", rsp_valid[k], 1'b0);
        chk("ready_idle", req_ready[k], 1'b1);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_be[k]    = be;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        model(k, we, be, addr, wd, erd, eerr, nb);
        exp_lat = (nb == 2) ? 2 + 2 * ws(k) : 1 + ws(k);
        @(posedge clk);
        #1;
        scramble(k);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 64 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid[k]) begin
                got = 1'b1;
                lat = c;
            end else begin
                chk("ready_busy", req_ready[k], 1'b0);
            end
        end
        chk("rsp_latency", lat, exp_lat);
        got_rd = 'x;
        if (got) begin
            chk("ready_at_rsp", req_ready[k], 1'b1);
            chk("rsp_rdata", rsp_rdata[k], erd);
            chk("rsp_err", rsp_err[k], eerr);
            got_rd = rsp_rdata[k];
        end
    endtask

    function automatic logic [11:0] raddr(input int k);
        case ($urandom_range(0, 3))
            0: return 12'($urandom_range(0, 60));
            1: return 12'(dep(k) - 32 + int'($urandom_range(0, 60)));
            2: return 12'($urandom_range(4092, 4095));
            default: return 12'($urandom_range(12'h2F0, 12'h31C));
        endcase
    endfunction

    function automatic logic [11:0] raddr_al(input int k);
        case ($urandom_range(0, 2))
            0: return 12'(4 * $urandom_range(0, 15));
            1: return 12'(dep(k) - 32 + 4 * int'($urandom_range(0, 15)));
            default: return 12'(12'h2F0 + 4 * $urandom_range(0, 11));
        endcase
    endfunction

    initial begin
        logic [31:0] prd;
        logic        perr;
        logic [31:0] erd;
        bit          eerr;
        int          nb;
        logic        we;
        logic [3:0]  be;
        logic [11:0] ad;
        logic [31:0] wd;

        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b0;
            scramble(k);
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++)
            rst_n[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("reset_ready", req_ready[k], 1'b1);
            chk("reset_valid", rsp_valid[k], 1'b0);
            chk("reset_rdata", rsp_rdata[k], 32'h0);
            chk("reset_err", rsp_err[k], 1'b0);
        end

        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 64; a += 4)
                do_req(k, 1'b1, 4'hF, 12'(a), $urandom | 32'h01010101, rd);
            for (int a = dep(k) - 32; a < dep(k); a += 4)
                do_req(k, 1'b1, 4'hF, 12'(a), $urandom | 32'h01010101, rd);
            for (int a = 12'h2F0; a < 12'h320; a += 4)
                do_req(k, 1'b1, 4'hF, 12'(a), $urandom | 32'h01010101, rd);
        end

        do_req(0, 1'b1, 4'b0011, 12'h100, 32'h0000BEEF, rd);
        do_req(0, 1'b0, 4'b0011, 12'h100, 32'h0, rd);
        chk("word_read", rd, 32'h0000BEEF);
        do_req(0, 1'b1, 4'b0011, 12'h103, 32'h00001234, rd);
        do_req(0, 1'b0, 4'b0001, 12'h103, 32'h0, rd);
        chk("split_lo", rd[7:0], 8'h34);
        do_req(0, 1'b0, 4'b0001, 12'h104, 32'h0, rd);
        chk("split_hi", rd[7:0], 8'h12);
        do_req(0, 1'b0, 4'b0011, 12'(DEP0 - 1), 32'h0, rd);
        chk("range_hi_lane", rd[15:8], 8'h00);
        do_req(0, 1'b1, 4'b0011, 12'hFFF, 32'h000077AA, rd);
        do_req(0, 1'b0, 4'b0001, 12'h000, 32'h0, rd);
        chk("wrap_byte", rd[7:0], 8'h77);
        do_req(0, 1'b0, 4'b0000, 12'h010, 32'h0, rd);
        do_req(1, 1'b1, 4'hF, 12'h2F6, 32'hA1B2C3D4, rd);
        do_req(1, 1'b0, 4'hF, 12'h2F4, 32'h0, rd);
        chk("width_upper", rd[31:16], 16'hC3D4);
        do_req(1, 1'b0, 4'hF, 12'h303, 32'h0, rd);

        for (int n = 0; n < 250; n++) begin
            for (int k = 0; k < NI; k++)
                do_req(k, 1'($urandom), 4'($urandom), raddr(k), $urandom, rd);
        end

        // Back-to-back single-beat stream on the zero-wait instance.
        @(negedge clk);
        prd  = '0;
        perr = 1'b0;
        for (int j = 0; j <= 40; j++) begin
            if (j > 0) begin
                chk("stream_valid", rsp_valid[0], 1'b1);
                chk("stream_rdata", rsp_rdata[0], prd);
                chk("stream_err", rsp_err[0], perr);
            end
            if (j < 40) begin
                chk("stream_ready", req_ready[0], 1'b1);
                we = 1'($urandom);
                be = 4'($urandom);
                ad = raddr_al(0);
                wd = $urandom;
                req_valid[0] = 1'b1;
                req_we[0]    = we;
                req_be[0]    = be;
                req_addr[0]  = ad;
                req_wdata[0] = wd;
                model(0, we, be, ad, wd, erd, eerr, nb);
                prd  = erd;
                perr = eerr;
            end else begin
                scramble(0);
            end
            @(negedge clk);
        end

        // Reset in the middle of the second wait phase of a split write.
        do_req(1, 1'b0, 4'hF, 12'h300, 32'h0, rd);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_be[1]    = 4'hF;
        req_addr[1]  = 12'h301;
        req_wdata[1] = 32'hA5C33C5A;
        @(posedge clk);
        #1;
        scramble(1);
        mdl[4096 + 12'h301] = 8'h5A;
        mdl[4096 + 12'h302] = 8'h3C;
        mdl[4096 + 12'h303] = 8'hC3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rst_pre_valid", rsp_valid[1], 1'b0);
        end
        rst_n[1] = 1'b0;
        #1;
        chk("rst_mid_valid", rsp_valid[1], 1'b0);
        chk("rst_mid_rdata", rsp_rdata[1], 32'h0);
        chk("rst_mid_err", rsp_err[1], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_no_rsp", rsp_valid[1], 1'b0);
        end
        chk("rst_ready", req_ready[1], 1'b1);
        chk("rst_rdata", rsp_rdata[1], 32'h0);
        do_req(1, 1'b0, 4'b0001, 12'h301, 32'h0, rd);
        chk("rst_beat0_byte", rd[7:0], 8'h5A);
        do_req(1, 1'b0, 4'b0001, 12'h304, 32'h0, rd);
        do_req(1, 1'b0, 4'hF, 12'h300, 32'h0, rd);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
